glitch_sequencer: RTL and testbench

- Controls one glitch shot sequence around the `pattern` shift engine.
- After software arms it, it waits for an external target trigger, counts a programmable delay, then fires `pattern` one or more times with a programmable gap between shots.
- Sits between the UART/command register file and the `pattern` instance. It owns `pattern`'s en/pattern/pattern_cnt inputs and consumes its rdy output.

---
 rtl/glitch_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_glitch_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_sequencer.sv
// Glitch shot sequencer: arm, wait for target trigger, delay, then fire the pattern engine N times with gaps.
// Optional arm timeout enabled by defining GLITCH_SEQ_TIMEOUT_EN.
module glitch_sequencer #(
    parameter int DLY_W = 32,
    parameter int GAP_W = 16,
    parameter int TMO_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             abort,
    input  logic             trig_in,
    input  logic             trig_pol,
    input  logic [DLY_W-1:0] cfg_delay,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic [7:0]       cfg_shots,
    input  logic [7:0]       cfg_pattern,
    input  logic [7:0]       cfg_pattern_cnt,
    input  logic [TMO_W-1:0] cfg_timeout,
    output logic             pat_en,
    output logic [7:0]       pat_data,
    output logic [7:0]       pat_cnt,
    input  logic             pat_rdy,
    output logic             busy,
    output logic             done,
    output logic             timeout
);

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_DELAY, S_FIRE, S_WAIT, S_GAP} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
    logic             trig_edge_q, trig_edge_d;
    logic             pol_q, pol_d;
    logic [DLY_W-1:0] delay_q, delay_d, dly_cnt_q, dly_cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d, gap_cnt_q, gap_cnt_d;
    logic [7:0]       shots_left_q, shots_left_d;
    logic [7:0]       pat_data_q, pat_data_d, pat_cnt_q, pat_cnt_d;
    logic             holdoff_q, holdoff_d;
    logic             done_q, done_d;
    logic             edge_raw;

`ifdef GLITCH_SEQ_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cfg_q, tmo_cfg_d, tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;
    assign timeout = timeout_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^cfg_timeout;
    assign timeout    = 1'b0;
`endif

    assign edge_raw = pol_q ? (sync2_q & ~hist_q) : (~sync2_q & hist_q);
    assign pat_data = pat_data_q;
    assign pat_cnt  = pat_cnt_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;

    always_comb begin
        state_d      = state_q;
        sync1_d      = trig_in;
        sync2_d      = sync1_q;
        hist_d       = sync2_q;
        // Edges seen outside ARMED never reach the FSM.
        trig_edge_d  = (state_q == S_ARMED) && edge_raw;
        pol_d        = pol_q;
        delay_d      = delay_q;
        dly_cnt_d    = dly_cnt_q;
        gap_d        = gap_q;
        gap_cnt_d    = gap_cnt_q;
        shots_left_d = shots_left_q;
        pat_data_d   = pat_data_q;
        pat_cnt_d    = pat_cnt_q;
        holdoff_d    = 1'b0;
        done_d       = 1'b0;
        pat_en       = 1'b0;
`ifdef GLITCH_SEQ_TIMEOUT_EN
        tmo_cfg_d    = tmo_cfg_q;
        tmo_cnt_d    = tmo_cnt_q;
        timeout_d    = 1'b0;
`endif
        if (abort) begin
            state_d      = S_IDLE;
            trig_edge_d  = 1'b0;
            dly_cnt_d    = '0;
            gap_cnt_d    = '0;
            shots_left_d = '0;
`ifdef GLITCH_SEQ_TIMEOUT_EN
            tmo_cnt_d    = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        pol_d        = trig_pol;
                        delay_d      = cfg_delay;
                        gap_d        = cfg_gap;
                        pat_data_d   = cfg_pattern;
                        pat_cnt_d    = cfg_pattern_cnt;
                        shots_left_d = (cfg_shots == 8'd0) ? 8'd1 : cfg_shots;
`ifdef GLITCH_SEQ_TIMEOUT_EN
                        tmo_cfg_d    = cfg_timeout;
                        tmo_cnt_d    = '0;
`endif
                        state_d      = S_ARMED;
                    end
                end
                S_ARMED: begin
`ifdef GLITCH_SEQ_TIMEOUT_EN
                    if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
`endif
                    if (trig_edge_q) begin
                        if (delay_q == '0) begin
                            state_d = S_FIRE;
                        end else begin
                            dly_cnt_d = delay_q;
                            state_d   = S_DELAY;
                        end
                    end
`ifdef GLITCH_SEQ_TIMEOUT_EN
                    else if (tmo_cfg_q != '0 && tmo_cnt_q == tmo_cfg_q - TMO_W'(1)) begin
                        timeout_d = 1'b1;
                        tmo_cnt_d = '0;
                        state_d   = S_IDLE;
                    end
`endif
                end
                S_DELAY: begin
                    dly_cnt_d = dly_cnt_q - DLY_W'(1);
                    if (dly_cnt_q == DLY_W'(1)) state_d = S_FIRE;
                end
                S_FIRE: begin
                    // A stall simply waits here; the trigger delay is not replayed.
                    if (pat_rdy) begin
                        pat_en       = 1'b1;
                        shots_left_d = shots_left_q - 8'd1;
                        holdoff_d    = 1'b1;
                        state_d      = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!holdoff_q && pat_rdy) begin
                        if (shots_left_q == 8'd0) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else if (gap_q == '0) begin
                            state_d = S_FIRE;
                        end else begin
                            gap_cnt_d = gap_q;
                            state_d   = S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    if (gap_cnt_q == GAP_W'(1)) state_d = S_FIRE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            hist_q       <= 1'b0;
            trig_edge_q  <= 1'b0;
            pol_q        <= 1'b0;
            delay_q      <= '0;
            dly_cnt_q    <= '0;
            gap_q        <= '0;
            gap_cnt_q    <= '0;
            shots_left_q <= '0;
            pat_data_q   <= '0;
            pat_cnt_q    <= '0;
            holdoff_q    <= 1'b0;
            done_q       <= 1'b0;
`ifdef GLITCH_SEQ_TIMEOUT_EN
            tmo_cfg_q    <= '0;
            tmo_cnt_q    <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            hist_q       <= hist_d;
            trig_edge_q  <= trig_edge_d;
            pol_q        <= pol_d;
            delay_q      <= delay_d;
            dly_cnt_q    <= dly_cnt_d;
            gap_q        <= gap_d;
            gap_cnt_q    <= gap_cnt_d;
            shots_left_q <= shots_left_d;
            pat_data_q   <= pat_data_d;
            pat_cnt_q    <= pat_cnt_d;
            holdoff_q    <= holdoff_d;
            done_q       <= done_d;
`ifdef GLITCH_SEQ_TIMEOUT_EN
            tmo_cfg_q    <= tmo_cfg_d;
            tmo_cnt_q    <= tmo_cnt_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Scoreboard bench for glitch_sequencer: expected pat_en/done/timeout events are queued with
// their cycle stamps when a scenario is started and checked as the DUT emits them.
module tb_glitch_sequencer;
    localparam int DLY_W = 32;
    localparam int GAP_W = 16;
    localparam int TMO_W = 32;
    localparam int PB    = 3;  // pattern stub busy length after each en

    localparam int EV_FIRE = 1;
    localparam int EV_DONE = 2;
    localparam int EV_TMO  = 3;

    typedef struct {
        int       kind;
        int       t;
        logic [7:0] d;
        logic [7:0] c;
    } ev_t;

    logic             clk = 1'b0, rst = 1'b1, arm = 1'b0, abort = 1'b0;
    logic             trig_in = 1'b0, trig_pol = 1'b1;
    logic [DLY_W-1:0] cfg_delay = '0;
    logic [GAP_W-1:0] cfg_gap = '0;
    logic [7:0]       cfg_shots = '0, cfg_pattern = '0, cfg_pattern_cnt = '0;
    logic [TMO_W-1:0] cfg_timeout = '0;
    logic             pat_en, pat_rdy, busy, done, timeout;
    logic [7:0]       pat_data, pat_cnt;

    int  cyc = 0;
    int  total = 0, bad = 0;
    ev_t exp_q[$];
    ev_t mon_e;
    int  mon_k;

    logic stub_rdy = 1'b1, hold_lo = 1'b0;
    int   bcnt = 0;

    glitch_sequencer #(.DLY_W(DLY_W), .GAP_W(GAP_W), .TMO_W(TMO_W)) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig_in(trig_in), .trig_pol(trig_pol),
        .cfg_delay(cfg_delay), .cfg_gap(cfg_gap), .cfg_shots(cfg_shots),
        .cfg_pattern(cfg_pattern), .cfg_pattern_cnt(cfg_pattern_cnt), .cfg_timeout(cfg_timeout),
        .pat_en(pat_en), .pat_data(pat_data), .pat_cnt(pat_cnt), .pat_rdy(pat_rdy),
        .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pattern engine stand-in: rdy drops after en and returns PB+1 cycles later.
    always @(posedge clk) begin
        if (pat_en) begin
            stub_rdy <= 1'b0;
            bcnt     <= PB;
        end else if (bcnt > 1) begin
            bcnt <= bcnt - 1;
        end else if (bcnt == 1) begin
            stub_rdy <= 1'b1;
            bcnt     <= 0;
        end
    end
    assign pat_rdy = stub_rdy & ~hold_lo;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (pat_en || done || timeout) begin
            mon_k = pat_en ? EV_FIRE : (done ? EV_DONE : EV_TMO);
            if (exp_q.size() == 0) begin
                chk("spurious_event", mon_k, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ev_kind", mon_k, mon_e.kind);
                chk("ev_cycle", cyc, mon_e.t);
                if (mon_k == EV_FIRE) begin
                    chk("ev_pat_data", pat_data, mon_e.d);
                    chk("ev_pat_cnt", pat_cnt, mon_e.c);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic pol, input int dly, input int gap, input int shots,
                          input int pat, input int cnt, input int tmo, output int a);
        trig_pol        = pol;
        cfg_delay       = DLY_W'(dly);
        cfg_gap         = GAP_W'(gap);
        cfg_shots       = 8'(shots);
        cfg_pattern     = 8'(pat);
        cfg_pattern_cnt = 8'(cnt);
        cfg_timeout     = TMO_W'(tmo);
        arm             = 1'b1;
        a               = cyc;
        tick(1);
        arm = 1'b0;
    endtask

    task automatic push_ev(input int kind, input int t, input int d, input int c);
        exp_q.push_back('{kind: kind, t: t, d: 8'(d), c: 8'(c)});
    endtask

    // Shot timeline: rdy returns PB+1 cycles after each en; gap idles then one FIRE cycle.
    task automatic push_run(input int f0, input int shots, input int gap, input int d, input int c);
        int f, r;
        f = f0;
        for (int k = 0; k < shots; k++) begin
            push_ev(EV_FIRE, f, d, c);
            r = f + PB + 1;
            if (k == shots - 1) push_ev(EV_DONE, r + 1, 0, 0);
            else f = (gap == 0) ? r + 1 : r + gap + 1;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, exp_q.size(), 0);
        exp_q.delete();
        tick(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int a, c0;
        tick(2);
        chk("rst_busy", busy, 0);
        chk("rst_pat_en", pat_en, 0);
        chk("rst_pat_data", pat_data, 0);
        chk("rst_pat_cnt", pat_cnt, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b0;
        tick(2);

        // single shot, delay 10
        do_arm(1'b1, 10, 0, 1, 8'h55, 0, 0, a);
        chk("single_busy_armed", busy, 1);
        tick(2);
        trig_in = 1'b1; c0 = cyc;
        push_run(c0 + 4 + 10, 1, 0, 8'h55, 0);
        drain("single_drain", 100);
        chk("single_busy_after", busy, 0);
        chk("single_data_hold", pat_data, 8'h55);
        trig_in = 1'b0;
        tick(4);

        // three shots, gap 5, delay 0
        do_arm(1'b1, 0, 5, 3, 8'hAA, 7, 0, a);
        tick(2);
        trig_in = 1'b1; c0 = cyc;
        push_run(c0 + 4, 3, 5, 8'hAA, 7);
        drain("multi_drain", 200);
        chk("multi_busy_after", busy, 0);
        trig_in = 1'b0;
        tick(4);

        // stall 20 cycles in FIRE
        do_arm(1'b1, 2, 0, 1, 8'h3C, 9, 0, a);
        hold_lo = 1'b1;
        tick(2);
        trig_in = 1'b1; c0 = cyc;
        push_run(c0 + 26, 1, 0, 8'h3C, 9);
        tick(16);
        chk("stall_pat_en_low", pat_en, 0);
        chk("stall_busy", busy, 1);
        tick(10);
        hold_lo = 1'b0;
        drain("stall_drain", 100);
        trig_in = 1'b0;
        tick(4);

        // falling polarity; pre-arm and wrong-direction edges are ignored
        trig_in = 1'b1; tick(3);
        trig_in = 1'b0; tick(3);
        trig_in = 1'b1; tick(3);
        trig_in = 1'b0; tick(5);
        chk("pol_prearm_idle", busy, 0);
        do_arm(1'b0, 1, 0, 1, 8'h0F, 2, 0, a);
        tick(3);
        trig_in = 1'b1;
        tick(8);
        chk("pol_rise_ignored", busy, 1);
        chk("pol_rise_quiet", exp_q.size(), 0);
        trig_in = 1'b0; c0 = cyc;
        push_run(c0 + 4 + 1, 1, 0, 8'h0F, 2);
        drain("pol_drain", 100);

        // arm while busy is ignored; abort during DELAY at dly_cnt=4
        trig_pol = 1'b1;
        do_arm(1'b1, 10, 0, 1, 8'h5A, 4, 0, a);
        tick(1);
        do_arm(1'b1, 0, 0, 1, 8'h33, 5, 0, a);
        chk("rearm_data_kept", pat_data, 8'h5A);
        chk("rearm_cnt_kept", pat_cnt, 4);
        tick(1);
        trig_in = 1'b1; c0 = cyc;
        tick(10);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("abort_idle", busy, 0);
        tick(20);
        chk("abort_quiet", exp_q.size(), 0);
        trig_in = 1'b0;
        tick(3);

        // abort beats arm in the same cycle
        cfg_pattern = 8'hEE; arm = 1'b1; abort = 1'b1;
        tick(1);
        arm = 1'b0; abort = 1'b0;
        chk("abort_arm_idle", busy, 0);
        chk("abort_arm_data", pat_data, 8'h5A);
        tick(2);

        // async reset while in WAIT
        do_arm(1'b1, 0, 0, 2, 8'h77, 3, 0, a);
        tick(1);
        trig_in = 1'b1; c0 = cyc;
        push_ev(EV_FIRE, c0 + 4, 8'h77, 3);
        tick(5);
        rst = 1'b1;
        #1;
        chk("wrst_busy", busy, 0);
        chk("wrst_pat_en", pat_en, 0);
        chk("wrst_pat_data", pat_data, 0);
        chk("wrst_pat_cnt", pat_cnt, 0);
        chk("wrst_done", done, 0);
        tick(2);
        rst = 1'b0;
        tick(20);
        chk("wrst_quiet", exp_q.size(), 0);
        trig_in = 1'b0;
        tick(3);

        // shots=0 behaves as one shot
        do_arm(1'b1, 3, 2, 0, 8'hC3, 1, 0, a);
        tick(1);
        trig_in = 1'b1; c0 = cyc;
        push_run(c0 + 4 + 3, 1, 2, 8'hC3, 1);
        drain("shots0_drain", 100);
        trig_in = 1'b0;
        tick(3);

        // 255 shots, back to back
        do_arm(1'b1, 0, 0, 255, 8'h96, 8'hFF, 0, a);
        tick(1);
        trig_in = 1'b1; c0 = cyc;
        push_run(c0 + 4, 255, 0, 8'h96, 8'hFF);
        drain("shots255_drain", 2000);
        chk("shots255_busy", busy, 0);
        trig_in = 1'b0;
        tick(3);

        // arm timeout
        do_arm(1'b1, 0, 0, 1, 8'h11, 1, 100, a);
`ifdef GLITCH_SEQ_TIMEOUT_EN
        push_ev(EV_TMO, a + 101, 0, 0);
        drain("tmo_drain", 200);
        chk("tmo_busy", busy, 0);
`else
        tick(150);
        chk("tmo_off_busy", busy, 1);
        abort = 1'b1; tick(1); abort = 1'b0;
        chk("tmo_off_abort", busy, 0);
`endif
        do_arm(1'b1, 0, 0, 1, 8'h11, 1, 0, a);
        tick(300);
        chk("tmo0_armed", busy, 1);
        abort = 1'b1; tick(1); abort = 1'b0;
        tick(2);
        chk("final_quiet", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
